// File: rtl/led_pattern_engine.sv
// Decorative LED sequencer with a run-time speed select and a two-digit pass counter.
//
// Ports:
//   clk_50 - system clock (50 MHz on board)
//   rst    - asynchronous active-high reset
//   en     - run enable; 0 freezes the prescaler, the pattern and the pass counter
//   mode   - 0 CHASE_R, 1 CHASE_L, 2 BOUNCE, 3 FILL, 4 BLINK, 5-7 OFF
//   speed  - tick period is CLK_DIV >> speed clocks
//   led    - LED drive, active-high, registered
//   hex0   - ones digit of the pass count, active-low gfedcba, registered
//   hex1   - tens digit of the pass count, same encoding
module led_pattern_engine #(
  parameter int unsigned NUM_LEDS = 27,
  parameter int unsigned CLK_DIV  = 25000000
) (
  input  logic                clk_50,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          mode,
  input  logic [1:0]          speed,
  output logic [NUM_LEDS-1:0] led,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1
);

  localparam logic [2:0] ModeChaseR = 3'd0;
  localparam logic [2:0] ModeChaseL = 3'd1;
  localparam logic [2:0] ModeBounce = 3'd2;
  localparam logic [2:0] ModeFill   = 3'd3;
  localparam logic [2:0] ModeBlink  = 3'd4;

  localparam logic [31:0]         ClkDivW = 32'(CLK_DIV);
  localparam logic [NUM_LEDS-1:0] LedOne  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LedMsb  = {1'b1, {(NUM_LEDS-1){1'b0}}};
  localparam logic [NUM_LEDS-1:0] LedAll  = {NUM_LEDS{1'b1}};

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

  logic [31:0]         cnt_q, cnt_d;
  logic [2:0]          active_mode_q, active_mode_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                loaded_q, loaded_d;
  logic                dir_up_q, dir_up_d;
  logic [3:0]          ones_q, ones_d;
  logic [3:0]          tens_q, tens_d;
  logic [6:0]          hex0_q, hex0_d;
  logic [6:0]          hex1_q, hex1_d;

  logic [31:0] div;
  logic        tick;
  logic        pass_inc;
  logic        going_up;

  always_comb begin
    div      = ClkDivW >> speed;
    // >= rather than == so a speed change that shortens DIV below the count still ticks
    tick     = en && (cnt_q >= (div - 32'd1));
    pass_inc = 1'b0;
    // Bounce keeps climbing until it hits MSB, then descends until it hits bit0
    going_up = (dir_up_q && !led_q[NUM_LEDS-1]) || (!dir_up_q && led_q[0]);

    cnt_d         = cnt_q;
    active_mode_d = active_mode_q;
    led_d         = led_q;
    loaded_d      = loaded_q;
    dir_up_d      = dir_up_q;
    ones_d        = ones_q;
    tens_d        = tens_q;

    if (mode != active_mode_q) begin
      // Mode change wins over everything, even with en low
      active_mode_d = mode;
      cnt_d         = '0;
      led_d         = '0;
      loaded_d      = 1'b0;
      dir_up_d      = 1'b1;
      ones_d        = '0;
      tens_d        = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
        if (active_mode_q <= ModeBlink) begin
          if (!loaded_q) begin
            loaded_d = 1'b1;
            dir_up_d = 1'b1;
            case (active_mode_q)
              ModeChaseR: led_d = LedMsb;
              ModeBlink:  led_d = LedAll;
              default:    led_d = LedOne;
            endcase
          end else begin
            case (active_mode_q)
              ModeChaseR: begin
                if (led_q[0]) begin
                  led_d    = LedMsb;
                  pass_inc = 1'b1;
                end else begin
                  led_d = led_q >> 1;
                end
              end
              ModeChaseL: begin
                if (led_q[NUM_LEDS-1]) begin
                  led_d    = LedOne;
                  pass_inc = 1'b1;
                end else begin
                  led_d = led_q << 1;
                end
              end
              ModeBounce: begin
                dir_up_d = going_up;
                if (going_up) begin
                  led_d = led_q << 1;
                end else begin
                  led_d    = led_q >> 1;
                  pass_inc = led_q[1];
                end
              end
              ModeFill: begin
                if (led_q == LedAll) begin
                  led_d    = '0;
                  pass_inc = 1'b1;
                end else if (led_q == '0) begin
                  led_d = LedOne;
                end else begin
                  led_d = (led_q << 1) | LedOne;
                end
              end
              ModeBlink: begin
                led_d    = ~led_q;
                pass_inc = (led_q == '0);
              end
              default: led_d = led_q;
            endcase
          end
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (pass_inc) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end

    // Decode from next-state so the display moves on the same edge as the count
    hex0_d = seg7(ones_d);
    hex1_d = seg7(tens_d);
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      active_mode_q <= ModeChaseR;
      led_q         <= '0;
      loaded_q      <= 1'b0;
      dir_up_q      <= 1'b1;
      ones_q        <= '0;
      tens_q        <= '0;
      hex0_q        <= 7'h40;
      hex1_q        <= 7'h40;
    end else begin
      cnt_q         <= cnt_d;
      active_mode_q <= active_mode_d;
      led_q         <= led_d;
      loaded_q      <= loaded_d;
      dir_up_q      <= dir_up_d;
      ones_q        <= ones_d;
      tens_q        <= tens_d;
      hex0_q        <= hex0_d;
      hex1_q        <= hex1_d;
    end
  end

  assign led  = led_q;
  assign hex0 = hex0_q;
  assign hex1 = hex1_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios with literal expectations
// followed by a randomized run, all checked every cycle against a phase-based model.
module tb_led_pattern_engine;

  localparam int N  = 8;
  localparam int CD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [1:0]   speed;
  logic [N-1:0] led;
  logic [6:0]   hex0;
  logic [6:0]   hex1;

  led_pattern_engine #(
    .NUM_LEDS(N),
    .CLK_DIV (CD)
  ) dut (
    .clk_50(clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .hex0  (hex0),
    .hex1  (hex1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: pattern expressed as a phase index within the mode's period
  int m_cnt, m_am, m_loaded, m_phase, m_pass;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int period(int m);
    case (m)
      0, 1:    return N;
      2:       return 2 * N - 2;
      3:       return N + 1;
      default: return 2;
    endcase
  endfunction

  function automatic int pass_phase(int m);
    return (m == 3) ? N : 0;
  endfunction

  function automatic logic [N-1:0] pat(int m, int p);
    int v;
    case (m)
      0:       v = 1 << (N - 1 - p);
      1:       v = 1 << p;
      2:       v = (p < N) ? (1 << p) : (1 << (2 * N - 2 - p));
      3:       v = (p < N) ? ((1 << (p + 1)) - 1) : 0;
      4:       v = (p == 0) ? ((1 << N) - 1) : 0;
      default: v = 0;
    endcase
    return v[N-1:0];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_am = 0; m_loaded = 0; m_phase = 0; m_pass = 0;
  endtask

  task automatic model_step();
    int div;
    if (rst) begin
      model_reset();
    end else begin
      div = CD >> speed;
      if (int'(mode) != m_am) begin
        m_am = int'(mode); m_cnt = 0; m_loaded = 0; m_phase = 0; m_pass = 0;
      end else if (en) begin
        if (m_cnt >= div - 1) begin
          m_cnt = 0;
          if (m_am < 5) begin
            if (m_loaded == 0) begin
              m_loaded = 1;
              m_phase  = 0;
            end else begin
              m_phase = (m_phase + 1) % period(m_am);
              if (m_phase == pass_phase(m_am)) m_pass = (m_pass + 1) % 100;
            end
          end
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_led;
    e_led = (m_loaded != 0 && m_am < 5) ? pat(m_am, m_phase) : '0;
    chk("model_led", led, e_led);
    chk("model_hex0", N'(hex0), N'(seg_tab[m_pass % 10]));
    chk("model_hex1", N'(hex1), N'(seg_tab[m_pass / 10]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; speed = 2'd3;
    #12;
    model_reset();
    compare();
    chk("reset_led", led, 8'h00);
    chk("reset_hex0", N'(hex0), 8'h40);
    rst = 1'b0;

    // 1: chase right at DIV=1
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("chase_r_seq", led, (i < 8) ? (8'h80 >> i) : 8'h80);
      if (i == 7) chk("chase_r_hex_pre", N'(hex0), 8'h40);
    end
    chk("chase_r_hex_wrap", N'(hex0), 8'h79);

    // 2: bounce, three round trips
    mode = 3'd2;
    step();
    chk("bounce_clear", led, 8'h00);
    steps(1 + 42);
    chk("bounce_led", led, 8'h01);
    chk("bounce_hex0", N'(hex0), 8'h30);
    chk("bounce_hex1", N'(hex1), 8'h40);

    // 3: fill at DIV=8
    mode = 3'd3; speed = 2'd0;
    step();
    steps(7);
    chk("fill_pre_load", led, 8'h00);
    step();
    chk("fill_load", led, 8'h01);
    steps(56);
    chk("fill_full", led, 8'hFF);
    chk("fill_hex_pre", N'(hex0), 8'h40);
    steps(8);
    chk("fill_empty", led, 8'h00);
    chk("fill_hex_inc", N'(hex0), 8'h79);
    steps(8);
    chk("fill_reload", led, 8'h01);

    // 4: blink through the 99 -> 00 wrap
    mode = 3'd4; speed = 2'd3;
    step();
    step();
    chk("blink_load", led, 8'hFF);
    steps(199);
    chk("blink_99_led", led, 8'h00);
    chk("blink_99_hex0", N'(hex0), 8'h10);
    chk("blink_99_hex1", N'(hex1), 8'h10);
    step();
    chk("blink_wrap_led", led, 8'hFF);
    chk("blink_wrap_hex0", N'(hex0), 8'h40);
    chk("blink_wrap_hex1", N'(hex1), 8'h40);

    // 5: mode change mid chase-left, then an enable pause
    mode = 3'd1;
    steps(2 + 3);
    chk("chase_l_mid", led, 8'h08);
    mode = 3'd3;
    step();
    chk("switch_clear", led, 8'h00);
    chk("switch_hex", N'(hex0), 8'h40);
    speed = 2'd1;
    steps(3);
    chk("switch_pre", led, 8'h00);
    step();
    chk("switch_load", led, 8'h01);
    steps(2);
    en = 1'b0;
    steps(20);
    chk("hold_led", led, 8'h01);
    en = 1'b1;
    step();
    chk("resume_1", led, 8'h01);
    step();
    chk("resume_2", led, 8'h03);

    // 6: async reset between edges, then an OFF mode
    mode = 3'd0; speed = 2'd3;
    steps(5);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_hex0", N'(hex0), 8'h40);
    chk("async_rst_hex1", N'(hex1), 8'h40);
    step();
    rst = 1'b0;
    mode = 3'd6;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("off_led", led, 8'h00);
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised decorative-LED sequencer. Successor to the fixed 27-LED, one-hot-switch combo block.
- Drives NUM_LEDS LEDs with one of five animation modes, selected by a binary mode bus.
- Speed is selectable at run time.
- Counts completed pattern passes (00-99, BCD) and shows the count on two active-low 7-segment digits.
- Sits at board top level: clocked from the 50 MHz board clock, fed directly by switches.

Parameters:
NUM_LEDS, 27, number of LED outputs; legal range 2..64.
CLK_DIV, 25000000, base prescaler period in clocks at speed=0; must be >= 8.

Ports:
clk_50  input  1  system clock (50 MHz on board).
rst  input  1  asynchronous active-high reset.
en  input  1  run enable; 0 freezes prescaler, pattern and counters.
mode  input  3  pattern select: 0 CHASE_R, 1 CHASE_L, 2 BOUNCE, 3 FILL, 4 BLINK, 5-7 OFF.
speed  input  2  tick period = DIV = CLK_DIV >> speed clocks.
led  output  NUM_LEDS  LED drive, active-high, registered.
hex0  output  7  ones digit of pass count, active-low, bit order gfedcba, registered.
hex1  output  7  tens digit of pass count, same encoding.

Behaviour:
- Reset (async, rst=1): led=0, prescaler=0, loaded=0, active_mode=0, pass BCD=00, hex0=hex1=7'h40 ("0").
- Prescaler: when en=1, counts 0..DIV-1. tick=1 when en=1 and count==DIV-1, and count returns to 0 on that edge. When en=0, count holds and there is no tick. DIV is recomputed from speed every cycle. If count>=DIV after a speed change, tick fires and count clears.
- Mode change has priority over tick. On any edge where mode != active_mode: active_mode<=mode, prescaler<=0, led<=0, loaded<=0, pass<=00. This applies regardless of en.
- First tick with loaded=0: load the initial pattern, set loaded=1, no pass increment. First LED output therefore appears DIV enabled cycles after en rises (or after a mode change).
- Subsequent ticks advance the pattern:
  - CHASE_R: init MSB only. Shift right one place. When bit0 is set, the next tick wraps to MSB and pass++. Period NUM_LEDS ticks.
  - CHASE_L: init bit0 only. Shift left. MSB wraps to bit0 with pass++.
  - BOUNCE: init bit0. Moves up to MSB, then down to bit0 (no dwell at the ends; direction flag internal). pass++ on each arrival at bit0. Period 2*NUM_LEDS-2 ticks.
  - FILL: init bit0 only. led <= (led<<1)|1 until all ones. The next tick gives 0 with pass++. The tick after that reloads bit0. Period NUM_LEDS+1 ticks.
  - BLINK: init all ones. Toggles every tick. pass++ on each transition 0 -> all ones.
  - OFF (5-7): led stays 0 and pass holds. Prescaler still runs, but ticks have no effect.
- Pass counter: two-digit BCD. 99 wraps to 00 on the next increment.
- hex0/hex1 update on the same edge as the pass count (registered decode, zero added latency).
- Segment codes 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).
- en falling mid-pattern: everything holds exactly. Resume continues from the held prescaler count.
- Reset asserted mid-operation returns all state to reset values immediately.

Test Plan:
1. NUM_LEDS=8, CLK_DIV=8, speed=3 (DIV=1), mode=0, reset then en=1 -> led sequence 80,40,20,...,01,80 on successive cycles; hex0 goes 40 -> 79 on the 80-after-01 edge.
2. Same setup, mode=2 -> led 01,02,...,80,40,...,01. pass increments once per 14 ticks; after 3 round trips hex0=30, hex1=40.
3. mode=3, speed=0 (DIV=8) -> first led=01 at 8th enabled cycle. Then 03,07,...,FF,00,01 every 8 cycles; pass increments on the FF -> 00 edge.
4. Run mode=4 for 200 ticks (100 passes) -> pass wraps 99 -> 00; hex1=hex0=40 after the wrap.
5. Mid-CHASE_L, set mode=3 -> next edge led=00, pass=00. Next tick led=01. Set en=0 for 20 cycles -> led/hex stable. en=1 resumes from the held count.
6. Assert rst asynchronously between clock edges mid-pattern -> led=0, hex0=hex1=40 before the next edge. Mode 6 after reset -> led stays 00 indefinitely.
